gray_sync_decoder: RTL and testbench

//  Fast-domain consumer of a 2-FF-synchronised Gray-coded counter/pointer from a slower domain.
//  - Debounces the synchronised word and converts Gray to binary.
//  - Checks that every accepted change is a single +1 step (wrap allowed).
//  - Emits a one-cycle update strobe per accepted step and a sticky error on an illegal jump.

---
 rtl/gray_sync_decoder_if.sv | 31 +++
 rtl/gray_sync_decoder.sv | 146 ++++++++++++++
 tb/tb_gray_sync_decoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_sync_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_sync_decoder_if
// Description : Bundle between a Gray-pointer source side and the
//               fast-domain decoder (Gray word, clear and decoded status).
// Revision    : 1.0  initial release
// ============================================================================
interface gray_sync_decoder_if #(
    parameter int W = 4
);
    logic [W-1:0] i_gray;       // synchronised Gray word
    logic         i_clr;        // synchronous clear
    logic [W-1:0] o_bin;        // last accepted value, binary
    logic         o_vld;        // one-cycle update strobe
    logic         o_dir;        // direction of last accepted step (1 = up)
    logic         o_err;        // sticky illegal-jump flag
    logic         o_init_done;  // first stable value captured

    // Source side: supplies the Gray word and clear, observes the status
    modport master (
        output i_gray, i_clr,
        input  o_bin, o_vld, o_dir, o_err, o_init_done
    );

    // Decoder side
    modport slave (
        input  i_gray, i_clr,
        output o_bin, o_vld, o_dir, o_err, o_init_done
    );
endinterface
`default_nettype wire

// File: rtl/gray_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray_sync_decoder
// Description : Fast-domain consumer of an already 2-FF synchronised Gray
//               counter. Debounces the word, converts it to binary, accepts
//               only single +1 steps (wrap allowed) and raises a sticky error
//               on any other jump.
//               Optional build macro: GRAY_DEC_DOWN_EN -- when defined, -1
//               steps are also legal and reported with o_dir = 0.
// Revision    : 1.0  initial release
// ============================================================================
module gray_sync_decoder #(
    parameter int W          = 4,   // Gray/binary word width (2..16)
    parameter int STABLE_CYC = 2    // identical samples needed to accept (1..15)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    gray_sync_decoder_if.slave   bus
);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    localparam logic [3:0]   c_stable = 4'(STABLE_CYC);
    localparam logic [W-1:0] c_one    = {{(W-1){1'b0}}, 1'b1};
`ifdef GRAY_DEC_DOWN_EN
    localparam logic [W-1:0] c_minus1 = {W{1'b1}};
`endif

    logic [W-1:0] r_g_q;
    logic [W-1:0] r_cand;
    logic [3:0]   r_cnt;
    logic [1:0]   r_state;
    logic [W-1:0] r_bin;
    logic         r_vld;
    logic         r_dir;
    logic         r_err;
    logic         r_init_done;

    logic         w_stable;
    logic [W-1:0] w_cand_bin;
    logic [W-1:0] w_delta;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_stable   = (r_cnt == c_stable);
    assign w_cand_bin = gray2bin(r_cand);
    assign w_delta    = w_cand_bin - r_bin;   // modulo 2^W by construction

    // Register the incoming word once more; tracking continues through clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_g_q <= '0;
        end else begin
            r_g_q <= bus.i_gray;
        end
    end

    // Candidate tracker: count how long the registered word has stayed put
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand <= '0;
            r_cnt  <= 4'd0;
        end else if (bus.i_clr) begin
            r_cand <= '0;
            r_cnt  <= 4'd0;
        end else if (r_g_q != r_cand) begin
            r_cand <= r_g_q;
            r_cnt  <= 4'd1;
        end else if (r_cnt < c_stable) begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    // Acceptance FSM: initial capture, step checking and error lock-up
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_INIT;
            r_bin       <= '0;
            r_vld       <= 1'b0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else if (bus.i_clr) begin
            // o_bin and o_dir keep their value until the next capture
            r_state     <= S_INIT;
            r_vld       <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (w_stable) begin
                        r_bin       <= w_cand_bin;
                        r_dir       <= 1'b1;
                        r_init_done <= 1'b1;
                        r_state     <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    // A stable candidate equal to o_bin is the value already held
                    if (w_stable && (w_cand_bin != r_bin)) begin
                        if (w_delta == c_one) begin
                            r_bin <= w_cand_bin;
                            r_vld <= 1'b1;
                            r_dir <= 1'b1;
`ifdef GRAY_DEC_DOWN_EN
                        end else if (w_delta == c_minus1) begin
                            r_bin <= w_cand_bin;
                            r_vld <= 1'b1;
                            r_dir <= 1'b0;
`endif
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    // Frozen until cleared; the input tracker keeps running
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.o_bin       = r_bin;
    assign bus.o_vld       = r_vld;
    assign bus.o_dir       = r_dir;
    assign bus.o_err       = r_err;
    assign bus.o_init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_gray_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_sync_decoder
// Description : Self-checking bench for gray_sync_decoder (W=4, STABLE_CYC=2)
//               using a sample-history model plus directed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_sync_decoder;

    localparam int W          = 4;
    localparam int STABLE_CYC = 2;
    localparam int MOD        = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    int base;

    // Gray code of 0..15, written out by hand
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_sync_decoder_if #(.W(W)) bus ();

    gray_sync_decoder #(.W(W), .STABLE_CYC(STABLE_CYC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: outputs derived from the history of sampled Gray words
    int m_bin, m_vld, m_dir, m_err, m_init, m_mode;  // mode 0 init, 1 track, 2 err
    logic [W-1:0] hist [$];

    function automatic int g2b(input int g);
        int r;
        r = 0;
        for (int n = 0; n < MOD; n++) begin
            if (((n ^ (n >> 1)) % MOD) == g) r = n;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_bin = 0; m_vld = 0; m_dir = 0; m_err = 0; m_init = 0; m_mode = 0;
        hist.delete();
        hist.push_back('0);
    endtask

    task automatic model_edge();
        bit stable;
        int cb, d, last;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (bus.i_clr) begin
            m_mode = 0; m_err = 0; m_init = 0; m_vld = 0;
            hist.delete();
            hist.push_back(bus.i_gray);
            return;
        end
        m_vld  = 0;
        stable = 0;
        cb     = 0;
        if (hist.size() >= STABLE_CYC + 1) begin
            last   = hist.size() - 2;
            stable = 1;
            for (int k = 0; k < STABLE_CYC; k++) begin
                if (hist[last - k] != hist[last]) stable = 0;
            end
            cb = g2b(int'(hist[last]));
        end
        if (stable) begin
            if (m_mode == 0) begin
                m_bin = cb; m_init = 1; m_dir = 1; m_mode = 1;
            end else if (m_mode == 1 && cb != m_bin) begin
                d = (cb - m_bin + MOD) % MOD;
                if (d == 1) begin
                    m_bin = cb; m_vld = 1; m_dir = 1;
`ifdef GRAY_DEC_DOWN_EN
                end else if (d == MOD - 1) begin
                    m_bin = cb; m_vld = 1; m_dir = 0;
`endif
                end else begin
                    m_err = 1; m_mode = 2;
                end
            end
        end
        hist.push_back(bus.i_gray);
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("bin",       32'(bus.o_bin),       m_bin);
        check("vld",       32'(bus.o_vld),       m_vld);
        check("dir",       32'(bus.o_dir),       m_dir);
        check("err",       32'(bus.o_err),       m_err);
        check("init_done", 32'(bus.o_init_done), m_init);
    endtask

    // Advance n clock edges, updating the model and comparing after each
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #2;
            compare_all();
            if (bus.o_vld === 1'b1) vld_seen++;
        end
    endtask

    initial begin
        bus.i_gray = 4'b0000;
        bus.i_clr  = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();

        // 1: reset state, then capture of 0000
        step(2);
        check("rst_bin",  32'(bus.o_bin), 0);
        check("rst_init", 32'(bus.o_init_done), 0);
        check("rst_err",  32'(bus.o_err), 0);
        rst_n = 1'b1;
        base  = vld_seen;
        step(4);
        check("t1_init", 32'(bus.o_init_done), 1);
        check("t1_bin",  32'(bus.o_bin), 0);
        check("t1_novld", vld_seen - base, 0);

        // 2: full up-count with wrap, four cycles per value
        base = vld_seen;
        for (int v = 1; v <= 16; v++) begin
            bus.i_gray = gtab[v % 16];
            step(4);
            check("t2_bin", 32'(bus.o_bin), v % 16);
        end
        check("t2_vld_count", vld_seen - base, 16);
        check("t2_err", 32'(bus.o_err), 0);
        check("t2_dir", 32'(bus.o_dir), 1);

        // 3: single-cycle glitch is ignored
        bus.i_gray = gtab[1];
        step(5);
        bus.i_gray = gtab[2];
        step(5);
        base = vld_seen;
        bus.i_gray = 4'b0111;
        step(1);
        bus.i_gray = 4'b0011;
        step(6);
        check("t3_novld", vld_seen - base, 0);
        check("t3_bin", 32'(bus.o_bin), 2);
        check("t3_err", 32'(bus.o_err), 0);

        // 4: jump 2 -> 5 is illegal, exactly STABLE_CYC+2 edges later
        base = vld_seen;
        bus.i_gray = 4'b0111;
        step(3);
        check("t4_err_early", 32'(bus.o_err), 0);
        step(1);
        check("t4_err", 32'(bus.o_err), 1);
        check("t4_bin", 32'(bus.o_bin), 2);
        check("t4_novld", vld_seen - base, 0);
        step(2);
        bus.i_clr = 1'b1;
        step(1);
        bus.i_clr = 1'b0;
        check("t4_clr_err", 32'(bus.o_err), 0);
        check("t4_clr_init", 32'(bus.o_init_done), 0);
        step(3);
        check("t4_reinit", 32'(bus.o_init_done), 1);
        check("t4_rebin", 32'(bus.o_bin), 5);

        // 5: 5 -> 6 up, then 6 -> 5 down
        bus.i_gray = 4'b0101;
        step(6);
        check("t5_bin6", 32'(bus.o_bin), 6);
        bus.i_gray = 4'b0111;
        step(6);
`ifdef GRAY_DEC_DOWN_EN
        check("t5_down_bin", 32'(bus.o_bin), 5);
        check("t5_down_dir", 32'(bus.o_dir), 0);
        check("t5_down_err", 32'(bus.o_err), 0);
`else
        check("t5_down_err", 32'(bus.o_err), 1);
        check("t5_down_bin", 32'(bus.o_bin), 6);
`endif

        // 6: asynchronous reset between edges, then clean re-init
        bus.i_clr = 1'b1;
        step(1);
        bus.i_clr = 1'b0;
        step(4);
        check("t6_pre_bin", 32'(bus.o_bin), 5);
        bus.i_gray = 4'b0101;
        step(2);
        #4 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_bin",  32'(bus.o_bin), 0);
        check("t6_async_init", 32'(bus.o_init_done), 0);
        check("t6_async_dir",  32'(bus.o_dir), 0);
        check("t6_async_err",  32'(bus.o_err), 0);
        check("t6_async_vld",  32'(bus.o_vld), 0);
        bus.i_gray = 4'b0010;
        step(2);
        rst_n = 1'b1;
        base  = vld_seen;
        step(6);
        check("t6_novld", vld_seen - base, 0);
        check("t6_init", 32'(bus.o_init_done), 1);
        check("t6_bin",  32'(bus.o_bin), 3);
        check("t6_err",  32'(bus.o_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
